// File: rtl/afu_port_flr_seq.sv
// Function-level-reset sequencer for AFU mux ports: queues FLR requests, pulses the matching
// per-port resets, waits for traffic to drain, then reports completion. Optional FLR_TIMEOUT_EN.
module afu_port_flr_seq #(
   parameter int                      NUM_PORTS      = 4,
   parameter logic [NUM_PORTS*3-1:0]  PORT_PF        = '0,
   parameter logic [NUM_PORTS*11-1:0] PORT_VF        = '0,
   parameter logic [NUM_PORTS-1:0]    PORT_VF_ACTIVE = '0,
   parameter int                      HOLD_CYCLES    = 16,
   parameter int                      TIMEOUT_CYCLES = 1024,
   parameter int                      FIFO_DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flr_req_valid,
   output logic                 flr_req_ready,
   input  logic [2:0]           flr_req_pf,
   input  logic [10:0]          flr_req_vf,
   input  logic                 flr_req_vf_active,
   input  logic [NUM_PORTS-1:0] port_busy,
   output logic [NUM_PORTS-1:0] port_rst_n,
   output logic                 flr_rsp_valid,
   output logic [2:0]           flr_rsp_pf,
   output logic [10:0]          flr_rsp_vf,
   output logic                 flr_rsp_vf_active,
   output logic                 flr_err,
   output logic [2:0]           o_dbg_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE   = 1;
   localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ASSERT  = 3'd1;
   localparam logic [2:0] S_HOLD    = 3'd2;
   localparam logic [2:0] S_DRAIN   = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;
   localparam logic [2:0] S_RESP    = 3'd5;

   logic [2:0]           r_state;
   logic                 r_started;
   logic [14:0]          r_fifo [FIFO_DEPTH];
   logic [AW:0]          r_wr_ptr;
   logic [AW:0]          r_rd_ptr;
   logic [2:0]           r_req_pf;
   logic [10:0]          r_req_vf;
   logic                 r_req_vfa;
   logic [NUM_PORTS-1:0] r_mask;
   logic [NUM_PORTS-1:0] r_port_rst_n;
   logic [7:0]           r_hold_cnt;
   logic                 r_rsp_valid;
   logic [2:0]           r_rsp_pf;
   logic [10:0]          r_rsp_vf;
   logic                 r_rsp_vfa;

   logic                 w_full;
   logic                 w_empty;
   logic                 w_push;
   logic                 w_pop;
   logic [NUM_PORTS-1:0] w_mask;
   logic                 w_drained;
   logic                 w_release_go;

   // Handshake: a request transfers on any clk edge where flr_req_valid and flr_req_ready are
   // both high; ready depends only on queue fullness, never on valid.
   assign w_empty       = (r_wr_ptr == r_rd_ptr);
   assign w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                          (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign flr_req_ready = r_started & ~w_full;
   assign w_push        = flr_req_valid & flr_req_ready;
   assign w_pop         = (r_state == S_IDLE) & ~w_empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr[AW-1:0]] <= {flr_req_pf, flr_req_vf, flr_req_vf_active};
      end
   end

   // A PF request hits every port of that PF; a VF request only the VF port with that number.
   always_comb begin
      w_mask = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (PORT_PF[p*3 +: 3] == r_req_pf) begin
            if (!r_req_vfa) begin
               w_mask[p] = 1'b1;
            end else if (PORT_VF_ACTIVE[p] && (PORT_VF[p*11 +: 11] == r_req_vf)) begin
               w_mask[p] = 1'b1;
            end
         end
      end
   end

   assign w_drained = ((port_busy & r_mask) == '0);

`ifdef FLR_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] r_drain_cnt;
   logic        r_err;
   logic        w_timeout;

   assign w_timeout    = ~w_drained & (r_drain_cnt == TO_LAST);
   assign w_release_go = w_drained | w_timeout;
   assign flr_err      = r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drain_cnt <= '0;
         r_err       <= 1'b0;
      end else begin
         if (r_state != S_DRAIN) begin
            r_drain_cnt <= '0;
         end else if (w_timeout) begin
            r_err <= 1'b1;
         end else if (!w_drained) begin
            r_drain_cnt <= r_drain_cnt + 16'd1;
         end
      end
   end
`else
   logic [15:0] w_unused_timeout;

   assign w_unused_timeout = 16'(TIMEOUT_CYCLES);
   assign w_release_go     = w_drained;
   assign flr_err          = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_started    <= 1'b0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_req_pf     <= '0;
         r_req_vf     <= '0;
         r_req_vfa    <= 1'b0;
         r_mask       <= '0;
         r_port_rst_n <= '0;
         r_hold_cnt   <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_pf     <= '0;
         r_rsp_vf     <= '0;
         r_rsp_vfa    <= 1'b0;
      end else begin
         // Ports leave reset on the first edge after rst falls.
         if (!r_started) begin
            r_started    <= 1'b1;
            r_port_rst_n <= '1;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         r_rsp_valid <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  {r_req_pf, r_req_vf, r_req_vfa} <= r_fifo[r_rd_ptr[AW-1:0]];
                  r_state <= S_ASSERT;
               end
            end
            S_ASSERT: begin
               r_mask     <= w_mask;
               r_hold_cnt <= '0;
               if (w_mask == '0) begin
                  r_state <= S_RESP;
               end else begin
                  r_port_rst_n <= r_port_rst_n & ~w_mask;
                  r_state      <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (r_hold_cnt == HOLD_LAST) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 8'd1;
               end
            end
            S_DRAIN: begin
               if (w_release_go) begin
                  r_port_rst_n <= r_port_rst_n | r_mask;
                  r_state      <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               r_state <= S_RESP;
            end
            S_RESP: begin
               r_rsp_valid <= 1'b1;
               r_rsp_pf    <= r_req_pf;
               r_rsp_vf    <= r_req_vf;
               r_rsp_vfa   <= r_req_vfa;
               r_state     <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign port_rst_n        = r_port_rst_n;
   assign flr_rsp_valid     = r_rsp_valid;
   assign flr_rsp_pf        = r_rsp_pf;
   assign flr_rsp_vf        = r_rsp_vf;
   assign flr_rsp_vf_active = r_rsp_vfa;
   assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_afu_port_flr_seq.sv
// Directed bench for afu_port_flr_seq: four ports PF {0,1,1,2}, port 2 is VF 3, hold 16 cycles.
module tb_afu_port_flr_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flr_req_valid = 1'b0;
   logic        flr_req_ready;
   logic [2:0]  flr_req_pf = '0;
   logic [10:0] flr_req_vf = '0;
   logic        flr_req_vf_active = 1'b0;
   logic [3:0]  port_busy = '0;
   logic [3:0]  port_rst_n;
   logic        flr_rsp_valid;
   logic [2:0]  flr_rsp_pf;
   logic [10:0] flr_rsp_vf;
   logic        flr_rsp_vf_active;
   logic        flr_err;
   logic [2:0]  o_dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [14:0] exp_q [$];
   logic [14:0] rsp_q [$];

   afu_port_flr_seq #(
      .NUM_PORTS      (4),
      .PORT_PF        ({3'd2, 3'd1, 3'd1, 3'd0}),
      .PORT_VF        ({11'd0, 11'd3, 11'd0, 11'd0}),
      .PORT_VF_ACTIVE (4'b0100),
      .HOLD_CYCLES    (16),
      .TIMEOUT_CYCLES (64),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .flr_req_valid     (flr_req_valid),
      .flr_req_ready     (flr_req_ready),
      .flr_req_pf        (flr_req_pf),
      .flr_req_vf        (flr_req_vf),
      .flr_req_vf_active (flr_req_vf_active),
      .port_busy         (port_busy),
      .port_rst_n        (port_rst_n),
      .flr_rsp_valid     (flr_rsp_valid),
      .flr_rsp_pf        (flr_rsp_pf),
      .flr_rsp_vf        (flr_rsp_vf),
      .flr_rsp_vf_active (flr_rsp_vf_active),
      .flr_err           (flr_err),
      .o_dbg_state       (o_dbg_state)
   );

   // Clock / reset and cycle index (cyc == number of posedges seen so far)
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (flr_rsp_valid === 1'b1) rsp_q.push_back({flr_rsp_pf, flr_rsp_vf, flr_rsp_vf_active});
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   // Driver: present one request at a negedge; acc is the index of the accepting posedge.
   task automatic send_req(input logic [2:0] pf, input logic [10:0] vf, input logic vfa,
                           output int acc);
      int g;
      g = 0;
      @(negedge clk);
      while (flr_req_ready !== 1'b1 && g < 200) begin
         @(negedge clk);
         g++;
      end
      flr_req_pf = pf;
      flr_req_vf = vf;
      flr_req_vf_active = vfa;
      flr_req_valid = 1'b1;
      acc = cyc + 1;
      @(negedge clk);
      flr_req_valid = 1'b0;
   endtask

   // Driver: send a request and observe its port-reset window and response pulse.
   task automatic run_req(input logic [2:0] pf, input logic [10:0] vf, input logic vfa,
                          output int acc, output int low_cnt, output logic [3:0] low_pat,
                          output logic pat_bad, output int rsp_at, output logic [14:0] rsp_val,
                          output int pulse);
      send_req(pf, vf, vfa, acc);
      low_cnt = 0; low_pat = 4'hF; pat_bad = 1'b0; rsp_at = -1; rsp_val = '0; pulse = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (port_rst_n !== 4'hF) begin
            if (low_cnt == 0) low_pat = port_rst_n;
            else if (port_rst_n !== low_pat) pat_bad = 1'b1;
            low_cnt++;
         end
         if (flr_rsp_valid === 1'b1) begin
            pulse++;
            if (rsp_at < 0) begin
               rsp_at  = cyc;
               rsp_val = {flr_rsp_pf, flr_rsp_vf, flr_rsp_vf_active};
            end
         end else if (rsp_at >= 0) begin
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++; if (port_rst_n !== 4'h0) begin n_fail++; $display("FAIL reset_port_rst_n got=%b exp=0000", port_rst_n); end
      n_tests++; if (flr_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", flr_req_ready); end
      n_tests++; if ({flr_rsp_valid, flr_rsp_pf, flr_rsp_vf, flr_rsp_vf_active, flr_err} !== 17'h0) begin
         n_fail++; $display("FAIL reset_rsp got=%b/%h/%h/%b err=%b exp=0", flr_rsp_valid, flr_rsp_pf, flr_rsp_vf, flr_rsp_vf_active, flr_err); end
      n_tests++; if (o_dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", o_dbg_state); end
      rst = 1'b0;
      #1;
      n_tests++; if (port_rst_n !== 4'h0) begin n_fail++; $display("FAIL reset_before_edge got=%b exp=0000", port_rst_n); end
      @(negedge clk);
      n_tests++; if (port_rst_n !== 4'hF) begin n_fail++; $display("FAIL reset_first_edge_ports got=%b exp=1111", port_rst_n); end
      n_tests++; if (flr_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_first_edge_ready got=%b exp=1", flr_req_ready); end
   endtask

   task automatic test_pf_request();
      int acc, low_cnt, rsp_at, pulse;
      logic [3:0] low_pat;
      logic pat_bad;
      logic [14:0] rsp_val;
      run_req(3'd1, 11'd0, 1'b0, acc, low_cnt, low_pat, pat_bad, rsp_at, rsp_val, pulse);
      n_tests++; if (low_pat !== 4'b1001) begin n_fail++; $display("FAIL pf1_pattern got=%b exp=1001", low_pat); end
      n_tests++; if (low_cnt != 17) begin n_fail++; $display("FAIL pf1_low_cycles got=%0d exp=17", low_cnt); end
      n_tests++; if (pat_bad !== 1'b0) begin n_fail++; $display("FAIL pf1_unmasked_change got=%b exp=0", pat_bad); end
      n_tests++; if (rsp_at - acc != 21) begin n_fail++; $display("FAIL pf1_rsp_latency got=%0d exp=21", rsp_at - acc); end
      n_tests++; if (rsp_val !== {3'd1, 11'd0, 1'b0}) begin n_fail++; $display("FAIL pf1_rsp_fields got=%h exp=%h", rsp_val, {3'd1, 11'd0, 1'b0}); end
      n_tests++; if (pulse != 1) begin n_fail++; $display("FAIL pf1_rsp_pulse_len got=%0d exp=1", pulse); end
      repeat (4) @(negedge clk);
      n_tests++; if ({flr_rsp_valid, flr_rsp_pf, flr_rsp_vf, flr_rsp_vf_active} !== {1'b0, 3'd1, 11'd0, 1'b0}) begin
         n_fail++; $display("FAIL pf1_rsp_hold got=%b/%h/%h/%b exp=0/1/000/0", flr_rsp_valid, flr_rsp_pf, flr_rsp_vf, flr_rsp_vf_active); end
   endtask

   task automatic test_vf_request();
      int acc, low_cnt, rsp_at, pulse;
      logic [3:0] low_pat;
      logic pat_bad;
      logic [14:0] rsp_val;
      run_req(3'd1, 11'd3, 1'b1, acc, low_cnt, low_pat, pat_bad, rsp_at, rsp_val, pulse);
      n_tests++; if (low_pat !== 4'b1011) begin n_fail++; $display("FAIL vf3_pattern got=%b exp=1011", low_pat); end
      n_tests++; if (low_cnt != 17 || pat_bad !== 1'b0) begin n_fail++; $display("FAIL vf3_low_cycles got=%0d bad=%b exp=17 bad=0", low_cnt, pat_bad); end
      n_tests++; if (rsp_at - acc != 21) begin n_fail++; $display("FAIL vf3_rsp_latency got=%0d exp=21", rsp_at - acc); end
      n_tests++; if (rsp_val !== {3'd1, 11'd3, 1'b1}) begin n_fail++; $display("FAIL vf3_rsp_fields got=%h exp=%h", rsp_val, {3'd1, 11'd3, 1'b1}); end
      run_req(3'd1, 11'd5, 1'b1, acc, low_cnt, low_pat, pat_bad, rsp_at, rsp_val, pulse);
      n_tests++; if (low_cnt != 0) begin n_fail++; $display("FAIL vf5_empty_mask_ports got=%0d low cycles (pattern %b) exp=0", low_cnt, low_pat); end
      n_tests++; if (rsp_at - acc != 3) begin n_fail++; $display("FAIL vf5_rsp_latency got=%0d exp=3", rsp_at - acc); end
      n_tests++; if (rsp_val !== {3'd1, 11'd5, 1'b1} || pulse != 1) begin n_fail++; $display("FAIL vf5_rsp_fields got=%h pulse=%0d exp=%h pulse=1", rsp_val, pulse, {3'd1, 11'd5, 1'b1}); end
   endtask

   task automatic test_busy_drain();
      int acc, drop, low, rsp_at;
      logic bad;
      port_busy = 4'b1001;
      send_req(3'd0, 11'd0, 1'b0, acc);
      drop = -1; low = 0; rsp_at = -1; bad = 1'b0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (port_rst_n === 4'b1110) low++;
         else if (port_rst_n !== 4'hF) bad = 1'b1;
         if (flr_rsp_valid === 1'b1 && rsp_at < 0) rsp_at = cyc;
         if (cyc == acc + 40) begin
            port_busy = 4'b0000;
            drop = cyc;
         end
         if (rsp_at >= 0) break;
      end
      n_tests++; if (low != 39 || bad !== 1'b0) begin n_fail++; $display("FAIL busy_port0_low got=%0d bad=%b exp=39 bad=0", low, bad); end
      n_tests++; if (rsp_at - drop != 3) begin n_fail++; $display("FAIL busy_rsp_after_drop got=%0d exp=3", rsp_at - drop); end
      n_tests++; if (flr_err !== 1'b0) begin n_fail++; $display("FAIL busy_err got=%b exp=0", flr_err); end
   endtask

   task automatic test_back_to_back();
      logic [14:0] items [6];
      int acc [6];
      int idx, blk, g;
      logic [14:0] e, o;
      items[0] = {3'd2, 11'd0, 1'b0};
      items[1] = {3'd3, 11'd7, 1'b0};
      items[2] = {3'd1, 11'd3, 1'b1};
      items[3] = {3'd0, 11'd0, 1'b0};
      items[4] = {3'd1, 11'd5, 1'b1};
      items[5] = {3'd4, 11'd9, 1'b0};
      for (int i = 0; i < 6; i++) acc[i] = 0;
      @(negedge clk);
      rsp_q.delete();
      exp_q.delete();
      idx = 0; blk = -1; g = 0;
      while (idx < 6 && g < 300) begin
         {flr_req_pf, flr_req_vf, flr_req_vf_active} = items[idx];
         flr_req_valid = 1'b1;
         if (flr_req_ready === 1'b1) begin
            acc[idx] = cyc + 1;
            exp_q.push_back(items[idx]);
            idx++;
         end else if (blk < 0) begin
            blk = cyc;
         end
         @(negedge clk);
         g++;
      end
      flr_req_valid = 1'b0;
      n_tests++; if (acc[4] - acc[0] != 4) begin n_fail++; $display("FAIL b2b_first_five got=%0d exp=4", acc[4] - acc[0]); end
      n_tests++; if (blk - acc[0] != 4) begin n_fail++; $display("FAIL b2b_ready_low_at got=%0d exp=4", blk - acc[0]); end
      n_tests++; if (acc[5] - acc[0] != 23) begin n_fail++; $display("FAIL b2b_sixth_accept got=%0d exp=23", acc[5] - acc[0]); end
      g = 0;
      while (rsp_q.size() < 6 && g < 400) begin
         @(negedge clk);
         g++;
      end
      n_tests++; if (rsp_q.size() != 6) begin n_fail++; $display("FAIL b2b_rsp_count got=%0d exp=6", rsp_q.size()); end
      while (exp_q.size() > 0 && rsp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = rsp_q.pop_front();
         n_tests++; if (o !== e) begin n_fail++; $display("FAIL b2b_rsp_order got=%h exp=%h", o, e); end
      end
   endtask

`ifdef FLR_TIMEOUT_EN
   task automatic test_timeout();
      int acc, rel_at, rsp_at;
      logic seen_low;
      port_busy = 4'b0001;
      send_req(3'd0, 11'd0, 1'b0, acc);
      rel_at = -1; rsp_at = -1; seen_low = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (port_rst_n !== 4'hF) seen_low = 1'b1;
         else if (seen_low && rel_at < 0) rel_at = cyc;
         if (flr_rsp_valid === 1'b1 && rsp_at < 0) rsp_at = cyc;
         if (rsp_at >= 0) break;
      end
      port_busy = 4'b0000;
      n_tests++; if (rel_at - acc != 82) begin n_fail++; $display("FAIL timeout_release got=%0d exp=82", rel_at - acc); end
      n_tests++; if (rsp_at - acc != 84) begin n_fail++; $display("FAIL timeout_rsp got=%0d exp=84", rsp_at - acc); end
      n_tests++; if (flr_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err got=%b exp=1", flr_err); end
   endtask
`endif

   task automatic test_reset_mid_sequence();
      int acc, pulses, g;
      logic bad;
      send_req(3'd1, 11'd0, 1'b0, acc);
      g = 0;
      while (cyc < acc + 8 && g < 50) begin
         @(negedge clk);
         g++;
      end
      n_tests++; if (port_rst_n !== 4'b1001) begin n_fail++; $display("FAIL midrst_in_hold got=%b exp=1001", port_rst_n); end
      #1 rst = 1'b1;
      #1;
      n_tests++; if (port_rst_n !== 4'h0 || flr_req_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_async got=%b ready=%b exp=0000 ready=0", port_rst_n, flr_req_ready); end
      n_tests++; if (flr_rsp_valid !== 1'b0 || flr_err !== 1'b0 || o_dbg_state !== 3'd0) begin
         n_fail++; $display("FAIL midrst_outputs got=v%b e%b s%0d exp=v0 e0 s0", flr_rsp_valid, flr_err, o_dbg_state); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_tests++; if (port_rst_n !== 4'hF || flr_req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_release got=%b ready=%b exp=1111 ready=1", port_rst_n, flr_req_ready); end
      n_tests++; if ({flr_rsp_pf, flr_rsp_vf, flr_rsp_vf_active} !== 15'h0) begin n_fail++; $display("FAIL midrst_rsp_cleared got=%h exp=0000", {flr_rsp_pf, flr_rsp_vf, flr_rsp_vf_active}); end
      pulses = 0; bad = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (flr_rsp_valid !== 1'b0) pulses++;
         if (port_rst_n !== 4'hF) bad = 1'b1;
      end
      n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL midrst_no_rsp got=%0d pulses exp=0", pulses); end
      n_tests++; if (bad !== 1'b0) begin n_fail++; $display("FAIL midrst_ports_stay_high got=%b exp=0", bad); end
   endtask

   initial begin
      test_reset();
      test_pf_request();
      test_vf_request();
      test_busy_drain();
      test_back_to_back();
`ifdef FLR_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_sequence();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
